// File: rtl/prbs7_xnor_pkg.sv
// Shared constants and types for the XNOR-feedback PRBS-7 generator/checker pair.
package prbs7_xnor_pkg;
  localparam int PRBS_LEN = 7;
  localparam int TAP_HI   = 6;
  localparam int TAP_LO   = 5;
  localparam logic [PRBS_LEN-1:0] LOCKUP_STATE = 7'h7F;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;
endpackage

// File: rtl/prbs7_xnor_checker_if.sv
// Stream-side signals of the PRBS-7 checker: qualified serial input, clear, lock/error status.
interface prbs7_xnor_checker_if #(
  parameter int ERR_W = 16
);
  logic             EN;
  logic             DIN;
  logic             CLR;
  logic             LOCK;
  logic             ERR;
  logic [ERR_W-1:0] ERR_CNT;

  modport master (output EN, DIN, CLR, input LOCK, ERR, ERR_CNT);
  modport slave  (input EN, DIN, CLR, output LOCK, ERR, ERR_CNT);
endinterface

// File: rtl/prbs7_xnor_lfsr.sv
// 7-bit x^7+x^6+1 XNOR LFSR; LOAD selects the externally supplied bit instead of feedback.
module prbs7_xnor_lfsr
  import prbs7_xnor_pkg::*;
(
  input  logic                CP,
  input  logic                RST,
  input  logic                EN,
  input  logic                LOAD,
  input  logic                LOAD_BIT,
  output logic [PRBS_LEN-1:0] S,
  output logic                PRED
);
  logic [PRBS_LEN-1:0] r_s;
  logic                w_pred;
  logic                w_in;

  assign w_pred = ~(r_s[TAP_HI] ^ r_s[TAP_LO]);
  assign w_in   = LOAD ? LOAD_BIT : w_pred;

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_s <= '0;
    end else if (EN) begin
      r_s <= {r_s[PRBS_LEN-2:0], w_in};
    end
  end

  assign S    = r_s;
  assign PRED = w_pred;
endmodule

// File: rtl/prbs7_xnor_checker.sv
// Self-synchronising PRBS-7 checker: seeds from the stream in SEARCH, free-runs and counts errors in LOCKED.
module prbs7_xnor_checker
  import prbs7_xnor_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic                 CP,
  input  logic                 RST,
  prbs7_xnor_checker_if.slave  bus
);
  localparam logic [7:0] LOCK_THR = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_THR = 8'(LOSS_CNT);

  chk_state_t          r_state, w_state;
  logic [7:0]          r_match, w_match;
  logic [7:0]          r_miss, w_miss;
  logic                r_err, w_err;
  logic [ERR_W-1:0]    r_err_cnt, w_err_cnt;
  logic [PRBS_LEN-1:0] w_s;
  logic                w_pred;
  logic                w_hit;
  logic                w_load;
  logic [7:0]          w_match_inc;
  logic [7:0]          w_miss_inc;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // In SEARCH the expected-bit register reloads from DIN; in LOCKED it free-runs.
  assign w_load = (r_state == SEARCH);

  prbs7_xnor_lfsr u_lfsr (
    .CP       (CP),
    .RST      (RST),
    .EN       (bus.EN),
    .LOAD     (w_load),
    .LOAD_BIT (bus.DIN),
    .S        (w_s),
    .PRED     (w_pred)
  );

  assign w_hit       = (bus.DIN == w_pred);
  assign w_match_inc = r_match + 8'd1;
  assign w_miss_inc  = r_miss + 8'd1;

  always_comb begin
    w_state   = r_state;
    w_match   = r_match;
    w_miss    = r_miss;
    w_err     = 1'b0;
    w_err_cnt = r_err_cnt;
    if (bus.EN) begin
      case (r_state)
        SEARCH: begin
          // The all-ones lockup pattern predicts 1 forever, so it must never count toward lock.
          if (w_hit && (w_s != LOCKUP_STATE)) begin
            if (w_match_inc == LOCK_THR) begin
              w_state = LOCKED;
              w_match = 8'd0;
              w_miss  = 8'd0;
            end else begin
              w_match = w_match_inc;
            end
          end else begin
            w_match = 8'd0;
          end
        end
        LOCKED: begin
          if (w_hit) begin
            w_miss = 8'd0;
          end else begin
            w_err     = 1'b1;
            w_err_cnt = sat_inc(r_err_cnt);
            if (w_miss_inc == LOSS_THR) begin
              w_state = SEARCH;
              w_match = 8'd0;
              w_miss  = 8'd0;
            end else begin
              w_miss = w_miss_inc;
            end
          end
        end
        default: w_state = SEARCH;
      endcase
    end
    if (bus.CLR) begin
      w_err_cnt = '0;
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_state   <= SEARCH;
      r_match   <= 8'd0;
      r_miss    <= 8'd0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_match   <= w_match;
      r_miss    <= w_miss;
      r_err     <= w_err;
      r_err_cnt <= w_err_cnt;
    end
  end

  assign bus.LOCK    = (r_state == LOCKED);
  assign bus.ERR     = r_err;
  assign bus.ERR_CNT = r_err_cnt;
endmodule
